// File: rtl/multi_led_calib_ctrl_if.sv
// Signal bundle between the LED calibration controller and the optical AFE:
// ADC sample stream in, LED/DAC/PGA controls and per-channel results out.
interface multi_led_calib_ctrl_if #(
  parameter int N_CH  = 2,
  parameter int ADC_W = 8,
  parameter int DC_W  = 7,
  parameter int PGA_W = 4
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  // sample_en and value_valid are valid-only strobes with no ready: the
  // receiver must take adc / ch_value in the single cycle the strobe is high.
  logic                  start;
  logic                  abort;
  logic                  sample_en;
  logic [ADC_W-1:0]      adc;
  logic [N_CH-1:0]       led_en;
  logic [3:0]            led_drive;
  logic [DC_W-1:0]       dc_comp;
  logic [PGA_W-1:0]      pga_gain;
  logic                  clk_filter;
  logic                  busy;
  logic                  cal_done;
  logic [N_CH-1:0]       cal_fail;
  logic [N_CH*ADC_W-1:0] ch_value;
  logic                  value_valid;
  logic [CH_W-1:0]       value_ch;
  logic [1:0]            dbg_state;

  modport master (
    output start, abort, sample_en, adc,
    input  led_en, led_drive, dc_comp, pga_gain, clk_filter, busy, cal_done,
           cal_fail, ch_value, value_valid, value_ch, dbg_state
  );

  modport slave (
    input  start, abort, sample_en, adc,
    output led_en, led_drive, dc_comp, pga_gain, clk_filter, busy, cal_done,
           cal_fail, ch_value, value_valid, value_ch, dbg_state
  );
endinterface

// File: rtl/multi_led_calib_ctrl.sv
// N-channel LED calibration (DC-compensation search, then PGA gain search)
// followed by time-multiplexed acquisition using the stored per-channel settings.
module multi_led_calib_ctrl #(
  parameter int N_CH      = 2,
  parameter int ADC_W     = 8,
  parameter int DC_W      = 7,
  parameter int PGA_W     = 4,
  parameter int DRIVE_DEF = 10,
  parameter int SETTLE    = 2,
  parameter int DC_WIN    = 10,
  parameter int PGA_WIN   = 50,
  parameter int DWELL     = 10,
  parameter int TGT_LO    = 110,
  parameter int TGT_HI    = 140,
  parameter int CLIP_LO   = 5,
  parameter int CLIP_HI   = 250
) (
  input  logic                  CLK,
  input  logic                  rst_n,
  multi_led_calib_ctrl_if.slave bus
);
  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = 16;

  localparam logic [DC_W-1:0]  DC_MID   = DC_W'(1) << (DC_W - 1);
  localparam logic [DC_W-1:0]  DC_MAX   = '1;
  localparam logic [PGA_W-1:0] PGA_MAX  = '1;
  localparam logic [CNT_W-1:0] SETTLE_C = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] DC_LAST  = CNT_W'(SETTLE + DC_WIN - 1);
  localparam logic [CNT_W-1:0] PGA_LAST = CNT_W'(SETTLE + PGA_WIN - 1);
  localparam logic [CNT_W-1:0] OP_LAST  = CNT_W'(SETTLE + DWELL - 1);
  localparam logic [ADC_W:0]   TGT_LO_C = (ADC_W+1)'(TGT_LO);
  localparam logic [ADC_W:0]   TGT_HI_C = (ADC_W+1)'(TGT_HI);
  localparam logic [ADC_W-1:0] CLIP_LO_C = ADC_W'(CLIP_LO);
  localparam logic [ADC_W-1:0] CLIP_HI_C = ADC_W'(CLIP_HI);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(N_CH - 1);

  typedef enum logic [1:0] {S_IDLE, S_DC_SRCH, S_PGA_SRCH, S_OPERATE} state_t;

  state_t                state_q, state_d;
  logic [CH_W-1:0]       ch_q, ch_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [ADC_W-1:0]      min_q, min_d, max_q, max_d;
  logic [DC_W-1:0]       dc_comp_q, dc_comp_d;
  logic [PGA_W-1:0]      pga_gain_q, pga_gain_d;
  logic [N_CH-1:0]       led_en_q, led_en_d;
  logic [N_CH-1:0]       cal_fail_q, cal_fail_d;
  logic [N_CH*ADC_W-1:0] ch_value_q, ch_value_d;
  logic                  value_valid_q, value_valid_d;
  logic [CH_W-1:0]       value_ch_q, value_ch_d;
  logic                  clk_filter_q, clk_filter_d;
  logic [DC_W-1:0]       dc_store_q  [N_CH];
  logic [DC_W-1:0]       dc_store_d  [N_CH];
  logic [PGA_W-1:0]      pga_store_q [N_CH];
  logic [PGA_W-1:0]      pga_store_d [N_CH];

  logic [ADC_W-1:0] min_n, max_n;
  logic [ADC_W:0]   avg;
  logic             clip, ch_is_last, restart, advance;
  logic [CH_W-1:0]  ch_inc;

  function automatic logic [N_CH-1:0] onehot(input logic [CH_W-1:0] c);
    onehot = N_CH'(1) << c;
  endfunction

  always_comb begin
    min_n      = (bus.adc < min_q) ? bus.adc : min_q;
    max_n      = (bus.adc > max_q) ? bus.adc : max_q;
    avg        = ({1'b0, max_n} + {1'b0, min_n}) >> 1;
    clip       = (min_n <= CLIP_LO_C) || (max_n >= CLIP_HI_C);
    ch_is_last = (ch_q == CH_LAST);
    ch_inc     = ch_is_last ? '0 : ch_q + CH_W'(1);
  end

  always_comb begin
    state_d       = state_q;
    ch_d          = ch_q;
    cnt_d         = cnt_q;
    min_d         = min_q;
    max_d         = max_q;
    dc_comp_d     = dc_comp_q;
    pga_gain_d    = pga_gain_q;
    led_en_d      = led_en_q;
    cal_fail_d    = cal_fail_q;
    ch_value_d    = ch_value_q;
    value_valid_d = 1'b0;
    value_ch_d    = value_ch_q;
    dc_store_d    = dc_store_q;
    pga_store_d   = pga_store_q;
    clk_filter_d  = ~clk_filter_q;
    restart       = 1'b0;
    advance       = 1'b0;

    if (bus.abort) begin
      state_d    = S_IDLE;
      led_en_d   = '0;
      dc_comp_d  = DC_MID;
      pga_gain_d = '0;
      cnt_d      = '0;
    end else if (bus.start && (state_q == S_IDLE || state_q == S_OPERATE)) begin
      state_d    = S_DC_SRCH;
      ch_d       = '0;
      cal_fail_d = '0;
      dc_comp_d  = DC_MID;
      pga_gain_d = '0;
      led_en_d   = onehot('0);
      restart    = 1'b1;
    end else if (bus.sample_en && state_q != S_IDLE) begin
      cnt_d = cnt_q + CNT_W'(1);
      if (cnt_q >= SETTLE_C) begin
        min_d = min_n;
        max_d = max_n;
      end
      unique case (state_q)
        S_DC_SRCH: if (cnt_q == DC_LAST) begin
          restart = 1'b1;
          // Stepping off either end of the code range is a rail hit, not a wrap.
          if (avg < TGT_LO_C && dc_comp_q != '0) begin
            dc_comp_d = dc_comp_q - DC_W'(1);
          end else if (avg > TGT_HI_C && dc_comp_q != DC_MAX) begin
            dc_comp_d = dc_comp_q + DC_W'(1);
          end else begin
            if (avg < TGT_LO_C || avg > TGT_HI_C) cal_fail_d[ch_q] = 1'b1;
            dc_store_d[ch_q] = dc_comp_q;
            state_d          = S_PGA_SRCH;
            pga_gain_d       = '0;
          end
        end
        S_PGA_SRCH: if (cnt_q == PGA_LAST) begin
          restart = 1'b1;
          if (clip) begin
            pga_store_d[ch_q] = (pga_gain_q == '0) ? '0 : pga_gain_q - PGA_W'(1);
            advance           = 1'b1;
          end else if (pga_gain_q != PGA_MAX) begin
            pga_gain_d = pga_gain_q + PGA_W'(1);
          end else begin
            pga_store_d[ch_q] = pga_gain_q;
            advance           = 1'b1;
          end
        end
        S_OPERATE: if (cnt_q == OP_LAST) begin
          restart                              = 1'b1;
          ch_value_d[int'(ch_q)*ADC_W +: ADC_W] = bus.adc;
          value_valid_d                        = 1'b1;
          value_ch_d                           = ch_q;
          ch_d                                 = ch_inc;
          led_en_d                             = onehot(ch_inc);
          dc_comp_d                            = dc_store_q[ch_inc];
          pga_gain_d                           = pga_store_q[ch_inc];
        end
        default: ;
      endcase

      // The last channel's gain is stored this cycle, so slot 0 reads the _d copy.
      if (advance) begin
        if (!ch_is_last) begin
          state_d    = S_DC_SRCH;
          ch_d       = ch_inc;
          led_en_d   = onehot(ch_inc);
          dc_comp_d  = DC_MID;
          pga_gain_d = '0;
        end else begin
          state_d    = S_OPERATE;
          ch_d       = '0;
          led_en_d   = onehot('0);
          dc_comp_d  = dc_store_d[0];
          pga_gain_d = pga_store_d[0];
        end
      end
    end

    if (restart) begin
      cnt_d = '0;
      min_d = '1;
      max_d = '0;
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      ch_q          <= '0;
      cnt_q         <= '0;
      min_q         <= '1;
      max_q         <= '0;
      dc_comp_q     <= DC_MID;
      pga_gain_q    <= '0;
      led_en_q      <= '0;
      cal_fail_q    <= '0;
      ch_value_q    <= '0;
      value_valid_q <= 1'b0;
      value_ch_q    <= '0;
      clk_filter_q  <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        dc_store_q[i]  <= '0;
        pga_store_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      ch_q          <= ch_d;
      cnt_q         <= cnt_d;
      min_q         <= min_d;
      max_q         <= max_d;
      dc_comp_q     <= dc_comp_d;
      pga_gain_q    <= pga_gain_d;
      led_en_q      <= led_en_d;
      cal_fail_q    <= cal_fail_d;
      ch_value_q    <= ch_value_d;
      value_valid_q <= value_valid_d;
      value_ch_q    <= value_ch_d;
      clk_filter_q  <= clk_filter_d;
      dc_store_q    <= dc_store_d;
      pga_store_q   <= pga_store_d;
    end
  end

  assign bus.led_en      = led_en_q;
  assign bus.led_drive   = (led_en_q != '0) ? 4'(DRIVE_DEF) : 4'd0;
  assign bus.dc_comp     = dc_comp_q;
  assign bus.pga_gain    = pga_gain_q;
  assign bus.clk_filter  = clk_filter_q;
  assign bus.busy        = (state_q == S_DC_SRCH) || (state_q == S_PGA_SRCH);
  assign bus.cal_done    = (state_q == S_OPERATE);
  assign bus.cal_fail    = cal_fail_q;
  assign bus.ch_value    = ch_value_q;
  assign bus.value_valid = value_valid_q;
  assign bus.value_ch    = value_ch_q;
  assign bus.dbg_state   = state_q;
endmodule

// File: doc/multi_led_calib_ctrl.md
Name: multi_led_calib_ctrl

Overview:
Parametrised N-channel calibration and acquisition controller for the optical analog front end.
- Calibration: per LED channel, it first searches the DC-compensation code that centres the ADC signal, then raises PGA gain up to the highest non-clipping setting.
- Operation: it time-multiplexes all channels using the stored per-channel settings and publishes one ADC value per channel.
- Placement: between the ADC sampler and the LED driver / DC DAC / PGA control pins.

Parameters:
N_CH, 2, number of LED channels (≥1)
ADC_W, 8, ADC sample width
DC_W, 7, DC-compensation code width
PGA_W, 4, PGA gain code width
DRIVE_DEF, 10, LED drive code (4 bit) applied while any LED is on
SETTLE, 2, sample strobes discarded after any setting or LED change
DC_WIN, 10, counted strobes per DC-search window
PGA_WIN, 50, counted strobes per PGA-search window
DWELL, 10, counted strobes per channel slot in operation
TGT_LO, 110, lower bound of DC target window (inclusive)
TGT_HI, 140, upper bound of DC target window (inclusive)
CLIP_LO, 5, clip detect: min ≤ CLIP_LO
CLIP_HI, 250, clip detect: max ≥ CLIP_HI

Ports:
CLK  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: begin calibration (ignored unless IDLE or OPERATE)
abort  in  1  level/pulse: return to IDLE, LEDs off
sample_en  in  1  ADC sample valid strobe
adc  in  ADC_W  ADC sample
led_en  out  N_CH  one-hot LED enable
led_drive  out  4  DRIVE_DEF when led_en≠0, else 0
dc_comp  out  DC_W  DC DAC code
pga_gain  out  PGA_W  PGA gain code
clk_filter  out  1  CLK/2 for the switched-cap filter
busy  out  1  high during calibration
cal_done  out  1  high in OPERATE
cal_fail  out  N_CH  per-channel flag: DC search hit a code rail
ch_value  out  N_CH*ADC_W  last captured sample per channel, channel k at bits [k*ADC_W +: ADC_W]
value_valid  out  1  one-cycle pulse when ch_value is updated
value_ch  out  clog2(N_CH) (min 1)  channel updated on value_valid

Behaviour:
- Reset (asynchronous): state IDLE; led_en=0, led_drive=0, dc_comp=2^(DC_W-1), pga_gain=0, clk_filter=0, busy=0, cal_done=0, cal_fail=0, ch_value=0, value_valid=0, value_ch=0; all stored settings cleared.
- clk_filter toggles every CLK edge after reset and is independent of the FSM.
- States: IDLE → DC_SRCH → PGA_SRCH → (next channel: DC_SRCH | last: OPERATE). Any state → IDLE on abort. Abort has priority over start in the same cycle.
- start in IDLE or OPERATE: ch=0, cal_fail cleared, dc_comp=mid, pga_gain=0, led_en=1<<0, enter DC_SRCH.
- Windows: only sample_en strobes count. The first SETTLE strobes after entering a window are discarded. The next N strobes update running min/max (min init all-ones, max init 0).
- DC_SRCH: after DC_WIN strobes, compute avg=(max+min)>>1 at ADC_W+1 bits, then:
  - avg<TGT_LO: dc_comp−1.
  - avg>TGT_HI: dc_comp+1.
  - Otherwise: store dc_comp for ch and go to PGA_SRCH with pga_gain=0.
  - Rail: if a required step would pass code 0 or 2^DC_W−1, do not wrap. Set cal_fail[ch], store the rail code, go to PGA_SRCH.
  - Every step restarts the window, including SETTLE.
- PGA_SRCH: after PGA_WIN strobes:
  - Clip (min≤CLIP_LO or max≥CLIP_HI): store max(gain−1,0), then advance.
  - No clip and gain<max: gain+1, restart window.
  - No clip and gain==max: store max, then advance.
- Advance: if ch<N_CH−1, then ch+1, led_en=1<<ch, dc_comp=mid, pga_gain=0, enter DC_SRCH. Otherwise enter OPERATE with ch=0.
- OPERATE: cal_done=1, busy=0.
  - Per slot: apply the stored dc_comp/pga_gain for ch, led_en=1<<ch.
  - Discard SETTLE strobes, then count DWELL strobes. On the DWELL-th strobe, write adc into ch_value[ch] and pulse value_valid with value_ch=ch.
  - The next cycle moves to ch+1 mod N_CH.
- busy=1 exactly in DC_SRCH and PGA_SRCH.
- Outputs are registered; settings change one cycle after the deciding strobe.
- N_CH=1: OPERATE keeps the single LED on continuously, and slots still repeat.

Test Plan:
- Reset mid-DC_SRCH (ch=1) → all outputs return to reset values immediately; start afterwards restarts at ch0 with dc_comp=64.
- Channel 0 sees a flat adc of 100 with default parameters → dc_comp steps 64→63 after each 12-strobe window. When adc is switched to 125, the search locks and PGA_SRCH begins with gain 0.
- PGA: ADC stays 20..230 until gain 3, then min drops to 2 → stored gain 2; gain 15 without clip → stored 15.
- DC rail: adc held at 200 → dc_comp climbs to 127, cal_fail[ch]=1, and calibration continues to PGA_SRCH.
- N_CH=3 operation: led_en cycles 001→010→100 every 12 strobes; value_valid pulses with value_ch 0,1,2 and ch_value holds adc at each 12th strobe. Per-slot dc_comp/pga_gain match the stored values.
- abort and start in the same cycle during OPERATE → IDLE, led_en=0, no value_valid thereafter.
